// File: rtl/cpu_dual_port_onchip_ram.sv
// Dual-port on-chip RAM: s1 is a CPU read/write port with byte enables, s2 is a read-only
// display port. Both share one array, accept one request per cycle, and return data after
// READ_LATENCY enabled cycles with a readdatavalid pulse. Out-of-range accesses set a
// sticky error flag; clken/reset_req stall the whole read pipeline.
module cpu_dual_port_onchip_ram #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned ADDR_WIDTH   = 17,
    parameter int unsigned DEPTH        = 76800,
    parameter int unsigned READ_LATENCY = 1,
    parameter string       INIT_FILE    = "cpu_dual_port_onchip_ram.hex"
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    clken_i,
    input  logic                    reset_req_i,
    input  logic [ADDR_WIDTH-1:0]   s1_address_i,
    input  logic                    s1_chipselect_i,
    input  logic                    s1_read_i,
    input  logic                    s1_write_i,
    input  logic [DATA_WIDTH/8-1:0] s1_byteenable_i,
    input  logic [DATA_WIDTH-1:0]   s1_writedata_i,
    output logic [DATA_WIDTH-1:0]   s1_readdata_o,
    output logic                    s1_readdatavalid_o,
    input  logic [ADDR_WIDTH-1:0]   s2_address_i,
    input  logic                    s2_read_i,
    output logic [DATA_WIDTH-1:0]   s2_readdata_o,
    output logic                    s2_readdatavalid_o,
    output logic                    range_err_o
);

    localparam int unsigned NumBytes = DATA_WIDTH / 8;
    localparam int unsigned IdxW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // One extra bit so DEPTH == 2**ADDR_WIDTH still compares correctly.
    localparam logic [ADDR_WIDTH:0] DepthLim = (ADDR_WIDTH + 1)'(DEPTH);

    // Contents are preloaded by the FPGA RAM flow from INIT_FILE.
    (* ram_init_file = INIT_FILE *) logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic                  en;
    logic                  s1_wr_acc, s1_rd_acc, s2_rd_acc;
    logic                  s1_oor, s2_oor;
    logic [IdxW-1:0]       s1_idx, s2_idx;
    logic [DATA_WIDTH-1:0] s1_rd_data_d, s2_rd_data_d;
    logic                  range_err_d, range_err_q;

    logic                  s1_vld1_q, s2_vld1_q;
    logic [DATA_WIDTH-1:0] s1_dat1_q, s2_dat1_q;

    // Request qualification, range check and array read for both ports.
    always_comb begin
        en           = clken_i & ~reset_req_i;
        s1_idx       = s1_address_i[IdxW-1:0];
        s2_idx       = s2_address_i[IdxW-1:0];
        s1_oor       = {1'b0, s1_address_i} >= DepthLim;
        s2_oor       = {1'b0, s2_address_i} >= DepthLim;
        s1_wr_acc    = en & s1_chipselect_i & s1_write_i;
        // A simultaneous read and write is serviced as a write only.
        s1_rd_acc    = en & s1_chipselect_i & s1_read_i & ~s1_write_i;
        s2_rd_acc    = en & s2_read_i;
        s1_rd_data_d = s1_oor ? '0 : mem_q[s1_idx];
        s2_rd_data_d = s2_oor ? '0 : mem_q[s2_idx];
        range_err_d  = range_err_q
                     | ((s1_wr_acc | s1_rd_acc) & s1_oor)
                     | (s2_rd_acc & s2_oor);
    end

    // Byte-masked write; reads in the same edge see the old word (read-before-write).
    always_ff @(posedge clk_i) begin
        if (!reset_i && s1_wr_acc && !s1_oor) begin
            for (int i = 0; i < NumBytes; i++) begin
                if (s1_byteenable_i[i]) begin
                    mem_q[s1_idx][8*i +: 8] <= s1_writedata_i[8*i +: 8];
                end
            end
        end
    end

    // First read stage and sticky error; everything holds while en is low.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            s1_vld1_q   <= 1'b0;
            s2_vld1_q   <= 1'b0;
            s1_dat1_q   <= '0;
            s2_dat1_q   <= '0;
            range_err_q <= 1'b0;
        end else if (en) begin
            s1_vld1_q   <= s1_rd_acc;
            s2_vld1_q   <= s2_rd_acc;
            range_err_q <= range_err_d;
            if (s1_rd_acc) s1_dat1_q <= s1_rd_data_d;
            if (s2_rd_acc) s2_dat1_q <= s2_rd_data_d;
        end
    end

    assign range_err_o = range_err_q;

    if (READ_LATENCY == 2) begin : g_lat2
        logic                  s1_vld2_q, s2_vld2_q;
        logic [DATA_WIDTH-1:0] s1_dat2_q, s2_dat2_q;

        // Output register stage; data only moves when a valid word moves with it.
        always_ff @(posedge clk_i) begin
            if (reset_i) begin
                s1_vld2_q <= 1'b0;
                s2_vld2_q <= 1'b0;
                s1_dat2_q <= '0;
                s2_dat2_q <= '0;
            end else if (en) begin
                s1_vld2_q <= s1_vld1_q;
                s2_vld2_q <= s2_vld1_q;
                if (s1_vld1_q) s1_dat2_q <= s1_dat1_q;
                if (s2_vld1_q) s2_dat2_q <= s2_dat1_q;
            end
        end

        // A stalled valid stays pending and only shows on an enabled cycle.
        always_comb begin
            s1_readdata_o      = s1_dat2_q;
            s2_readdata_o      = s2_dat2_q;
            s1_readdatavalid_o = s1_vld2_q & en;
            s2_readdatavalid_o = s2_vld2_q & en;
        end
    end else begin : g_lat1
        // A stalled valid stays pending and only shows on an enabled cycle.
        always_comb begin
            s1_readdata_o      = s1_dat1_q;
            s2_readdata_o      = s2_dat1_q;
            s1_readdatavalid_o = s1_vld1_q & en;
            s2_readdatavalid_o = s2_vld1_q & en;
        end
    end

endmodule

// File: tb/tb_cpu_dual_port_onchip_ram.sv
// Directed bench: drives one set of inputs into a READ_LATENCY=1 and a READ_LATENCY=2
// instance and checks both against hand-computed values.
module tb_cpu_dual_port_onchip_ram;

    localparam int unsigned DW    = 32;
    localparam int unsigned AW    = 17;
    localparam int unsigned DEPTH = 76800;

    logic          clk = 1'b0;
    logic          reset, clken, reset_req;
    logic [AW-1:0] s1_addr, s2_addr;
    logic          s1_cs, s1_rd, s1_wr, s2_rd;
    logic [3:0]    s1_be;
    logic [DW-1:0] s1_wdata;

    logic [DW-1:0] l1_s1_rdata, l1_s2_rdata, l2_s1_rdata, l2_s2_rdata;
    logic          l1_s1_vld, l1_s2_vld, l2_s1_vld, l2_s2_vld, l1_err, l2_err;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    always #5 clk = ~clk;

    cpu_dual_port_onchip_ram #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .READ_LATENCY(1), .INIT_FILE("")
    ) u_dut_l1 (
        .clk_i(clk), .reset_i(reset), .clken_i(clken), .reset_req_i(reset_req),
        .s1_address_i(s1_addr), .s1_chipselect_i(s1_cs), .s1_read_i(s1_rd),
        .s1_write_i(s1_wr), .s1_byteenable_i(s1_be), .s1_writedata_i(s1_wdata),
        .s1_readdata_o(l1_s1_rdata), .s1_readdatavalid_o(l1_s1_vld),
        .s2_address_i(s2_addr), .s2_read_i(s2_rd),
        .s2_readdata_o(l1_s2_rdata), .s2_readdatavalid_o(l1_s2_vld),
        .range_err_o(l1_err)
    );

    cpu_dual_port_onchip_ram #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .READ_LATENCY(2), .INIT_FILE("")
    ) u_dut_l2 (
        .clk_i(clk), .reset_i(reset), .clken_i(clken), .reset_req_i(reset_req),
        .s1_address_i(s1_addr), .s1_chipselect_i(s1_cs), .s1_read_i(s1_rd),
        .s1_write_i(s1_wr), .s1_byteenable_i(s1_be), .s1_writedata_i(s1_wdata),
        .s1_readdata_o(l2_s1_rdata), .s1_readdatavalid_o(l2_s1_vld),
        .s2_address_i(s2_addr), .s2_read_i(s2_rd),
        .s2_readdata_o(l2_s2_rdata), .s2_readdatavalid_o(l2_s2_vld),
        .range_err_o(l2_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        s1_cs    = 1'b0;
        s1_rd    = 1'b0;
        s1_wr    = 1'b0;
        s1_be    = 4'h0;
        s1_wdata = '0;
        s1_addr  = '0;
        s2_rd    = 1'b0;
        s2_addr  = '0;
    endtask

    task automatic set_s1_wr(input int unsigned addr, input logic [31:0] data,
                             input logic [3:0] be);
        s1_cs    = 1'b1;
        s1_wr    = 1'b1;
        s1_rd    = 1'b0;
        s1_addr  = AW'(addr);
        s1_wdata = data;
        s1_be    = be;
    endtask

    task automatic set_s1_rd(input int unsigned addr);
        s1_cs   = 1'b1;
        s1_rd   = 1'b1;
        s1_wr   = 1'b0;
        s1_addr = AW'(addr);
    endtask

    task automatic set_s2_rd(input int unsigned addr);
        s2_rd   = 1'b1;
        s2_addr = AW'(addr);
    endtask

    // One s2 read, three stalled cycles (with a write and an s1 read that must be ignored),
    // then the pending word must appear on the first enabled cycle (L1) or the second (L2).
    task automatic run_stall(input bit use_req, input int unsigned addr, input logic [31:0] exp);
        drive_idle(); set_s2_rd(addr); tick();
        for (int k = 0; k < 3; k++) begin
            drive_idle();
            if (use_req) reset_req = 1'b1;
            else         clken     = 1'b0;
            if (k == 0) set_s1_wr(addr, 32'h0, 4'hF);
            if (k == 1) set_s1_rd(addr);
            #1;
            check($sformatf("stall%0d_l1_s2_vld_%0d", use_req, k), 32'(l1_s2_vld), 32'd0);
            check($sformatf("stall%0d_l2_s2_vld_%0d", use_req, k), 32'(l2_s2_vld), 32'd0);
            tick();
        end
        drive_idle(); clken = 1'b1; reset_req = 1'b0; #1;
        check($sformatf("stall%0d_l1_s2_vld", use_req), 32'(l1_s2_vld), 32'd1);
        check($sformatf("stall%0d_l1_s2_data", use_req), l1_s2_rdata, exp);
        check($sformatf("stall%0d_l2_s2_vld_early", use_req), 32'(l2_s2_vld), 32'd0);
        check($sformatf("stall%0d_l1_s1_vld_none", use_req), 32'(l1_s1_vld), 32'd0);
        tick(); #1;
        check($sformatf("stall%0d_l1_s2_vld_pulse", use_req), 32'(l1_s2_vld), 32'd0);
        check($sformatf("stall%0d_l2_s2_vld", use_req), 32'(l2_s2_vld), 32'd1);
        check($sformatf("stall%0d_l2_s2_data", use_req), l2_s2_rdata, exp);
        check($sformatf("stall%0d_l2_s1_vld_none", use_req), 32'(l2_s1_vld), 32'd0);
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; clken = 1'b1; reset_req = 1'b0;
        drive_idle();
        tick(); tick(); #1;
        check("rst_l1_s1_rdata", l1_s1_rdata, 32'h0);
        check("rst_l1_s1_vld",   32'(l1_s1_vld), 32'd0);
        check("rst_l1_s2_vld",   32'(l1_s2_vld), 32'd0);
        check("rst_l1_err",      32'(l1_err), 32'd0);
        check("rst_l2_s2_rdata", l2_s2_rdata, 32'h0);
        check("rst_l2_err",      32'(l2_err), 32'd0);
        reset = 1'b0;

        // Byte lanes, including an all-zero byteenable write that must change nothing.
        drive_idle(); set_s1_wr(5, 32'hAABBCCDD, 4'hF);   tick();
        drive_idle(); set_s1_wr(5, 32'h11223344, 4'b0101); tick();
        drive_idle(); set_s1_wr(5, 32'hFFFFFFFF, 4'b0000); tick();
        drive_idle(); set_s1_rd(5); #1;
        check("lane_l1_vld_early", 32'(l1_s1_vld), 32'd0);
        tick();
        drive_idle(); #1;
        check("lane_l1_vld",       32'(l1_s1_vld), 32'd1);
        check("lane_l1_data",      l1_s1_rdata, 32'hAA22CC44);
        check("lane_l2_vld_early", 32'(l2_s1_vld), 32'd0);
        tick(); #1;
        check("lane_l1_vld_pulse", 32'(l1_s1_vld), 32'd0);
        check("lane_l1_hold",      l1_s1_rdata, 32'hAA22CC44);
        check("lane_l2_vld",       32'(l2_s1_vld), 32'd1);
        check("lane_l2_data",      l2_s1_rdata, 32'hAA22CC44);
        tick(); #1;
        check("lane_l2_vld_pulse", 32'(l2_s1_vld), 32'd0);

        // Back-to-back reads of words 0,1,2.
        for (int i = 0; i < 3; i++) begin
            drive_idle(); set_s1_wr(i, 32'(i), 4'hF); tick();
        end
        for (int i = 0; i < 6; i++) begin
            drive_idle();
            if (i < 3) set_s1_rd(i);
            #1;
            check($sformatf("pipe_l1_vld%0d", i), 32'(l1_s1_vld), 32'(i >= 1 && i <= 3));
            if (i >= 1 && i <= 3) check($sformatf("pipe_l1_data%0d", i), l1_s1_rdata, 32'(i - 1));
            check($sformatf("pipe_l2_vld%0d", i), 32'(l2_s1_vld), 32'(i >= 2 && i <= 4));
            if (i >= 2 && i <= 4) check($sformatf("pipe_l2_data%0d", i), l2_s1_rdata, 32'(i - 2));
            tick();
        end

        // s1 write vs s2 read on the same word, then rereads on both ports.
        drive_idle(); set_s1_wr(7, 32'h12345678, 4'hF); tick();
        drive_idle(); set_s1_wr(7, 32'hDEADBEEF, 4'hF); set_s2_rd(7); tick();
        drive_idle(); set_s2_rd(7); set_s1_rd(7); #1;
        check("col_l1_s2_vld", 32'(l1_s2_vld), 32'd1);
        check("col_l1_s2_old", l1_s2_rdata, 32'h12345678);
        tick();
        drive_idle(); #1;
        check("col_l1_s2_new", l1_s2_rdata, 32'hDEADBEEF);
        check("col_l1_s1_raw", l1_s1_rdata, 32'hDEADBEEF);
        check("col_l2_s2_old", l2_s2_rdata, 32'h12345678);
        tick(); #1;
        check("col_l2_s2_new", l2_s2_rdata, 32'hDEADBEEF);
        check("col_l2_s1_raw", l2_s1_rdata, 32'hDEADBEEF);
        tick();

        // Range boundary: last word is legal, DEPTH is not.
        drive_idle(); set_s1_wr(DEPTH - 1, 32'h5A5A5A5A, 4'hF); #1;
        check("rng_err_clear", 32'(l1_err), 32'd0);
        tick();
        drive_idle(); set_s1_wr(DEPTH, 32'hCAFEF00D, 4'hF); #1;
        check("rng_err_before", 32'(l1_err), 32'd0);
        tick();
        drive_idle(); set_s1_rd(DEPTH); set_s2_rd(DEPTH); #1;
        check("rng_l1_err_set", 32'(l1_err), 32'd1);
        check("rng_l2_err_set", 32'(l2_err), 32'd1);
        tick();
        drive_idle(); set_s1_rd(DEPTH - 1); #1;
        check("rng_l1_s1_vld",  32'(l1_s1_vld), 32'd1);
        check("rng_l1_s1_zero", l1_s1_rdata, 32'h0);
        check("rng_l1_s2_vld",  32'(l1_s2_vld), 32'd1);
        check("rng_l1_s2_zero", l1_s2_rdata, 32'h0);
        tick();
        drive_idle(); #1;
        check("rng_l1_last",    l1_s1_rdata, 32'h5A5A5A5A);
        check("rng_l2_s1_vld",  32'(l2_s1_vld), 32'd1);
        check("rng_l2_s1_zero", l2_s1_rdata, 32'h0);
        check("rng_l2_s2_zero", l2_s2_rdata, 32'h0);
        tick(); #1;
        check("rng_l2_last",    l2_s1_rdata, 32'h5A5A5A5A);
        check("rng_l1_sticky",  32'(l1_err), 32'd1);
        tick();

        // Stalls via clken and via reset_req; stalled writes of zero must be dropped.
        run_stall(1'b0, 5, 32'hAA22CC44);
        run_stall(1'b1, 7, 32'hDEADBEEF);

        // Reset while an L2 read is in flight.
        drive_idle(); set_s1_rd(5); tick();
        drive_idle(); reset = 1'b1; tick();
        reset = 1'b0; drive_idle(); #1;
        check("rstm_l2_vld",      32'(l2_s1_vld), 32'd0);
        check("rstm_l2_rdata",    l2_s1_rdata, 32'h0);
        check("rstm_l1_rdata",    l1_s1_rdata, 32'h0);
        check("rstm_l1_s2_rdata", l1_s2_rdata, 32'h0);
        check("rstm_l1_err",      32'(l1_err), 32'd0);
        check("rstm_l2_err",      32'(l2_err), 32'd0);
        tick(); #1;
        check("rstm_l2_vld_late", 32'(l2_s1_vld), 32'd0);
        drive_idle(); set_s1_rd(5); set_s2_rd(7); tick();
        drive_idle(); #1;
        check("rstm_l1_mem5", l1_s1_rdata, 32'hAA22CC44);
        check("rstm_l1_mem7", l1_s2_rdata, 32'hDEADBEEF);
        tick(); #1;
        check("rstm_l2_vld_after", 32'(l2_s1_vld), 32'd1);
        check("rstm_l2_mem5", l2_s1_rdata, 32'hAA22CC44);
        check("rstm_l2_mem7", l2_s2_rdata, 32'hDEADBEEF);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
